// File: rtl/uarc_receiver_port.sv
// Receiver-side endpoint of one UARC bus: acks remote kill/incept/send/stream
// requests, buffers words in a small FIFO and hands events to the core.
module uarc_receiver_port #(
  parameter int unsigned WORD_MAG       = 5,
  parameter int unsigned FIFO_DEPTH_MAG = 2,
  localparam int unsigned WORD_WIDTH    = 1 << WORD_MAG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  kill,
  output logic                  kill_ack,
  input  logic                  incept,
  output logic                  incept_ack,
  input  logic                  send,
  output logic                  send_ack,
  input  logic                  stream,
  output logic                  stream_ack,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic [WORD_WIDTH-1:0] incept_permission,
  input  logic [WORD_WIDTH-1:0] incept_address,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_is_stream,
  input  logic                  word_pop,
  output logic                  stream_end,
  output logic                  incept_pending,
  output logic [WORD_WIDTH-1:0] incept_perm_out,
  output logic [WORD_WIDTH-1:0] incept_addr_out,
  input  logic                  incept_take,
  output logic                  kill_pending,
  input  logic                  kill_done
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_MAG;
  localparam int unsigned PTR_W = FIFO_DEPTH_MAG + 1;
  localparam int unsigned IDX_W = FIFO_DEPTH_MAG;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAMING = 2'd1,
    KILLING   = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [WORD_WIDTH-1:0]   mem_data_q   [DEPTH];
  logic                    mem_stream_q [DEPTH];
  logic                    stream_end_q;
  logic                    incept_pending_q;
  logic [WORD_WIDTH-1:0]   incept_perm_q;
  logic [WORD_WIDTH-1:0]   incept_addr_q;
  logic                    kill_pending_q;

  logic fifo_full, fifo_empty;
  logic kill_req, killing, kill_busy, kill_finish;
  logic push, pop;

  // Request arbitration: kill > incept > stream > send, one ack at most.
  always_comb begin
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                  (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    kill_req    = enable && kill;
    killing     = (state_q == KILLING);
    kill_busy   = killing || kill_req;
    kill_finish = killing && kill_done;
    kill_ack    = !reset && killing && kill_req && kill_done;
    incept_ack  = !reset && enable && incept && !incept_pending_q && !kill_busy;
    stream_ack  = !reset && enable && stream && !fifo_full && !kill_busy && !incept_ack;
    send_ack    = !reset && enable && send && !stream && !fifo_full &&
                  !kill_busy && !incept_ack;
    push        = stream_ack || send_ack;
    pop         = word_pop && !fifo_empty;
  end

  // FIFO pointer next-state; a completed kill flushes the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (kill_finish) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Port state, FIFO storage and latched incept/kill status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      stream_end_q     <= 1'b0;
      incept_pending_q <= 1'b0;
      incept_perm_q    <= '0;
      incept_addr_q    <= '0;
      kill_pending_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data_q[i]   <= '0;
        mem_stream_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stream_end_q <= 1'b0;

      if (push) begin
        mem_data_q[wr_ptr_q[IDX_W-1:0]]   <= data;
        mem_stream_q[wr_ptr_q[IDX_W-1:0]] <= stream_ack;
      end

      if (incept_ack) begin
        incept_pending_q <= 1'b1;
        incept_perm_q    <= incept_permission;
        incept_addr_q    <= incept_address;
      end else if (incept_take) begin
        incept_pending_q <= 1'b0;
      end

      case (state_q)
        KILLING: begin
          if (kill_done) begin
            state_q          <= IDLE;
            kill_pending_q   <= 1'b0;
            incept_pending_q <= 1'b0;
          end
        end
        STREAMING: begin
          if (kill_req) begin
            state_q        <= KILLING;
            kill_pending_q <= 1'b1;
          end else if (!(enable && stream)) begin
            state_q      <= IDLE;
            stream_end_q <= 1'b1;
          end
        end
        default: begin
          if (kill_req) begin
            state_q        <= KILLING;
            kill_pending_q <= 1'b1;
          end else if (stream_ack) begin
            state_q <= STREAMING;
          end
        end
      endcase
    end
  end

  assign word_valid      = !fifo_empty;
  assign word_data       = mem_data_q[rd_ptr_q[IDX_W-1:0]];
  assign word_is_stream  = mem_stream_q[rd_ptr_q[IDX_W-1:0]];
  assign stream_end      = stream_end_q;
  assign incept_pending  = incept_pending_q;
  assign incept_perm_out = incept_perm_q;
  assign incept_addr_out = incept_addr_q;
  assign kill_pending    = kill_pending_q;

endmodule

// File: doc/uarc_receiver_port.md
Name: uarc_receiver_port

Overview:
- Receiver-side endpoint of one UARC bus; one instance per bus in front of a core's receiver_* inputs.
- Accepts kill, incept, send and stream requests from the remote sender and generates the matching acks.
- Buffers send/stream words in a small FIFO and presents kill, incept and data events to the core through a simple pop/take interface.

Parameters:
- WORD_MAG, 5, log2 of the word width; WORD_WIDTH = 1 << WORD_MAG.
- FIFO_DEPTH_MAG, 2, log2 of the word FIFO depth; depth = 1 << FIFO_DEPTH_MAG.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bus enabled by the remote sender; no request is accepted while low.
- kill  input  1  kill request, level.
- kill_ack  output  1  kill accepted.
- incept  input  1  incept request, level.
- incept_ack  output  1  incept accepted.
- send  input  1  single-word send request, level.
- send_ack  output  1  send word accepted.
- stream  input  1  stream request, level; held high for the whole stream.
- stream_ack  output  1  stream word accepted.
- data  input  WORD_WIDTH  send/stream word.
- incept_permission  input  WORD_WIDTH  permission for the incepted context.
- incept_address  input  WORD_WIDTH  address for the incepted context.
- word_valid  output  1  FIFO not empty.
- word_data  output  WORD_WIDTH  FIFO head word.
- word_is_stream  output  1  head word arrived via stream.
- word_pop  input  1  core consumes the head word; ignored when empty.
- stream_end  output  1  one-cycle pulse: the remote sender ended a stream.
- incept_pending  output  1  a latched incept is waiting.
- incept_perm_out  output  WORD_WIDTH  latched incept_permission.
- incept_addr_out  output  WORD_WIDTH  latched incept_address.
- incept_take  input  1  core accepts the pending incept.
- kill_pending  output  1  a kill is waiting for the core.
- kill_done  input  1  core has torn down its context.

Behaviour:
- Handshake convention: the sender holds each request high. A transfer occurs on any cycle where the request and its ack are both high. Acks are combinational; the sender may hold send/stream high to transfer one word per cycle.
- Reset values: all acks 0, word_valid 0, stream_end 0, incept_pending 0, kill_pending 0, FIFO pointers 0, state IDLE, word_data/incept outputs 0.
- States:
  - IDLE: no stream or kill in progress.
  - STREAMING: stream accepted, stream not yet dropped.
  - KILLING: kill latched, waiting for the core.
- Priority among simultaneous requests: kill > incept > stream > send. At most one ack is high in any cycle.
- Kill:
  - In IDLE or STREAMING, enable && kill sets kill_pending on the next edge and enters KILLING. No ack is given yet.
  - In KILLING, kill_ack = enable && kill && kill_done.
  - On that edge: flush the FIFO (pointers to 0), clear incept_pending, clear kill_pending, return to IDLE.
  - In KILLING, all other acks are 0.
  - If kill drops before being acked, the port still completes the flush on kill_done and returns to IDLE with no ack.
- Incept:
  - incept_ack = enable && incept && !incept_pending && !(kill path active).
  - On the transfer edge, latch permission/address and set incept_pending.
  - incept_take clears incept_pending on the next edge; incept_take while not pending is ignored.
- Send: send_ack = enable && send && !full && no higher-priority request. Push {data, is_stream=0}.
- Stream:
  - stream_ack = enable && stream && !full && no kill/incept ack. Push {data, is_stream=1}.
  - Entering STREAMING happens on the first accepted word.
  - In STREAMING, stream low (or enable low) returns the port to IDLE and pulses stream_end exactly one cycle later.
  - While the FIFO is full, the sender stalls with no ack and stays in STREAMING.
- FIFO:
  - Pointers are FIFO_DEPTH_MAG+1 bits and wrap modulo 2*depth.
  - full when the MSBs differ and the low bits are equal; empty when all bits are equal.
  - Simultaneous push and pop when full is not allowed (the ack is already low). Simultaneous push and pop when non-empty keeps the count constant. A pop when empty is a no-op.
  - word_data/word_is_stream show the head combinationally from the storage array.
- Reset asserted mid-stream or mid-kill: everything returns to reset values on that edge; no stream_end pulse and no ack that cycle.

Test Plan:
- Reset, then enable=1, send=1, data=0xDEADBEEF for 1 cycle -> send_ack=1 that cycle; next cycle word_valid=1, word_data=0xDEADBEEF, word_is_stream=0; word_pop -> word_valid=0.
- Stream of 6 words 1..6 with no pops, depth 4 -> acks on words 1-4, stream_ack=0 while full. Pop one per cycle -> words 5 and 6 accepted in order; stream drop -> stream_end pulses once after the final accept.
- incept=1, addr=0x100, perm=0xF -> incept_ack for 1 cycle, incept_pending=1 with the latched values. A second incept gets no ack until incept_take.
- kill, incept and send all raised in the same cycle with 2 words queued -> only the kill path proceeds, kill_pending=1. kill_done=1 -> kill_ack=1, FIFO empty, incept_pending=0, state IDLE.
- reset pulsed while STREAMING with 3 words queued -> next cycle word_valid=0, stream_end never pulses, all acks 0.
